// File: rtl/xdma_arb_pkg.sv
// Shared types and constants for the XDMA stream lock arbiter.
package xdma_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
endpackage

// File: rtl/xdma_rr_picker.sv
// Combinational picker: first set request at or above ptr, wrapping to the lowest set bit.
module xdma_rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  logic [N-1:0] req_hi;

  always_comb begin
    req_hi = '0;
    for (int i = 0; i < N; i++) req_hi[i] = req[i] && (i >= int'(ptr));
  end

  // Lowest overall request is the wrap-around fallback; a request at/above ptr overrides it.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = IDX_W'(i);
    if (|req_hi)
      for (int i = N - 1; i >= 0; i--) if (req_hi[i]) idx = IDX_W'(i);
  end
endmodule

// File: rtl/xdma_stream_lock_arbiter.sv
// N-input stream arbiter that locks a grant from start_o until done_i.
module xdma_stream_lock_arbiter
  import xdma_arb_pkg::*;
#(
  parameter type data_t        = logic,
  parameter int  N_INP         = 2,
  parameter int  RR_MODE       = ARB_RR,
  parameter int  BEAT_CNT_W    = 16,
  localparam int IDX_W         = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  data_t [N_INP-1:0]     inp_data_i,
  input  logic  [N_INP-1:0]     inp_valid_i,
  output logic  [N_INP-1:0]     inp_ready_o,
  input  logic  [N_INP-1:0]     inp_mask_i,
  output data_t                 oup_data_o,
  output logic                  oup_valid_o,
  input  logic                  oup_ready_i,
  input  logic                  done_i,
  output logic                  start_o,
  output logic                  busy_o,
  output logic [IDX_W-1:0]      grant_idx_o,
  output logic [BEAT_CNT_W-1:0] beat_cnt_o
);
  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       grant_idx_q, rr_ptr_q, pick_ptr, pick_idx;
  logic [BEAT_CNT_W-1:0]  beat_cnt_q;
  logic [N_INP-1:0]       req;
  logic                   pick_vld, take, hs;

  assign req      = inp_valid_i & inp_mask_i;
  assign pick_ptr = (RR_MODE == ARB_RR) ? rr_ptr_q : '0;
  // Reset wins over a pending request so no grant is taken in a reset cycle.
  assign take     = (state_q == IDLE) && pick_vld && !rst_i;
  assign hs       = busy_o && oup_valid_o && oup_ready_i;

  xdma_rr_picker #(.N(N_INP), .IDX_W(IDX_W)) u_picker (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = BUSY;
      BUSY:    if (done_i)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_o     = take;
    busy_o      = (state_q == BUSY);
    inp_ready_o = '0;
    oup_valid_o = 1'b0;
    oup_data_o  = '0;
    if (state_q == BUSY) begin
      for (int i = 0; i < N_INP; i++) begin
        if (grant_idx_q == IDX_W'(i)) begin
          oup_valid_o    = inp_valid_i[i];
          oup_data_o     = inp_data_i[i];
          inp_ready_o[i] = oup_ready_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
    end else if (take) begin
      grant_idx_q <= pick_idx;
      beat_cnt_q  <= '0;
      if (RR_MODE == ARB_RR)
        rr_ptr_q <= (int'(pick_idx) == N_INP - 1) ? '0 : pick_idx + 1'b1;
    end else if (hs && beat_cnt_q != '1) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  assign grant_idx_o = grant_idx_q;
  assign beat_cnt_o  = beat_cnt_q;
endmodule
